// File: rtl/arm_isa_pkg.sv
// Package: arm_isa_pkg
// Purpose: shared ARM-style ISA constants for the instruction encoder/writer
//          (op codes, data-processing cmd codes, MUL tag, condition codes),
//          the encoder FSM state type and the bundle legality rule.
// Ports:   none (package).
package arm_isa_pkg;

  // Instruction class field, instr[27:26]
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  // Data-processing cmd codes, funct[4:1]
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  // Fixed bits [7:4] that mark a multiply
  localparam logic [3:0] MUL_TAG = 4'b1001;

  // Condition codes, instr[31:28]
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NE = 4'b0001;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_WR   = 3'd2,
    ST_DONE = 3'd3,
    ST_FULL = 3'd4
  } enc_state_t;

  // A bundle is illegal for the reserved op, or for MUL requested outside
  // the DP class or with a non-zero cmd field.
  function automatic logic is_illegal(input logic [1:0] op,
                                      input logic       mul,
                                      input logic [3:0] cmd);
    return (op == OP_ILL) || (mul && ((op != OP_DP) || (cmd != 4'b0000)));
  endfunction

endpackage

// File: rtl/instr_encoder_writer_if.sv
// Interface: instr_encoder_writer_if
// Purpose: field-bundle handshake between the program loader (master) and
//          the instruction encoder/writer (slave).
// Signals: in_valid/in_ready handshake, in_last end-of-program marker,
//          cond/op/funct/mul/rn/rd/src2 instruction fields.
interface instr_encoder_writer_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic        mul;
  logic [3:0]  rn;
  logic [3:0]  rd;
  logic [11:0] src2;

  modport master (output in_valid, in_last, cond, op, funct, mul, rn, rd, src2,
                  input  in_ready);
  modport slave  (input  in_valid, in_last, cond, op, funct, mul, rn, rd, src2,
                  output in_ready);
endinterface

// File: rtl/instr_encoder_writer_pack.sv
// Module: instr_pack
// Purpose: purely combinational packing of instruction fields into a 32-bit
//          ARM-style word, plus the legality flag for the bundle.
// Ports:   cond/op/funct/mul/rn/rd/src2 in; word (packed instruction) and
//          illegal (bundle must be rejected) out.
module instr_pack
  import arm_isa_pkg::*;
(
  input  logic [3:0]  cond,
  input  logic [1:0]  op,
  input  logic [5:0]  funct,
  input  logic        mul,
  input  logic [3:0]  rn,
  input  logic [3:0]  rd,
  input  logic [11:0] src2,
  output logic [31:0] word,
  output logic        illegal
);

  // Field packing; MUL moves rd to [19:16], takes Rm from src2[11:8] and
  // places Rn in [3:0], with the accumulate bit [21] fixed at 0.
  always_comb begin
    word    = 32'h0000_0000;
    illegal = is_illegal(op, mul, funct[4:1]);
    if (mul) begin
      word = {cond, 6'b000000, 1'b0, funct[0], rd, 4'b0000, src2[11:8], MUL_TAG, rn};
    end else begin
      word = {cond, op, funct, rn, rd, src2};
    end
  end

endmodule

// File: rtl/instr_encoder_writer.sv
// Module: instr_encoder_writer
// Purpose: accepts instruction field bundles, packs them into 32-bit words
//          and writes them one per two cycles into instruction memory starting
//          at BASE_ADDR. Illegal bundles are rejected and flagged.
// Ports:   clk, reset (async active-low), start (load pulse), bus (field
//          bundle handshake, slave side), mem_we/mem_addr/mem_wdata (imem
//          write port), count (words written), busy/done/full/err_illegal.
module instr_encoder_writer
  import arm_isa_pkg::*;
#(
  parameter  logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter  int          DEPTH     = 64,
  localparam int          IDXW      = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  instr_encoder_writer_if.slave   bus,
  output logic                    mem_we,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  output logic [IDXW:0]           count,
  output logic                    busy,
  output logic                    done,
  output logic                    full,
  output logic                    err_illegal
);

  localparam logic [IDXW:0] DEPTH_CNT = (IDXW+1)'(DEPTH);

  enc_state_t    state_r;
  logic          in_ready_r;
  logic          mem_we_r;
  logic [31:0]   mem_addr_r;
  logic [31:0]   mem_wdata_r;
  logic [IDXW:0] count_r;
  logic          busy_r;
  logic          done_r;
  logic          full_r;
  logic          err_illegal_r;
  logic          last_r;
  logic          restart_pend_r;

  logic [31:0]   word_s;
  logic          illegal_s;
  logic [31:0]   addr_s;
  logic          accept_s;
  logic          restart_s;

  instr_pack u_pack (
    .cond    (bus.cond),
    .op      (bus.op),
    .funct   (bus.funct),
    .mul     (bus.mul),
    .rn      (bus.rn),
    .rd      (bus.rd),
    .src2    (bus.src2),
    .word    (word_s),
    .illegal (illegal_s)
  );

  // The word index is the low bits of count; count stops at DEPTH, so the
  // address never wraps back over earlier words.
  assign addr_s    = BASE_ADDR + {{(30-IDXW){1'b0}}, count_r[IDXW-1:0], 2'b00};
  assign accept_s  = bus.in_valid & in_ready_r;
  // A start seen during WR is remembered and taken once the write retires.
  assign restart_s = (start | restart_pend_r) & (state_r != ST_WR);

  assign bus.in_ready = in_ready_r;
  assign mem_we       = mem_we_r;
  assign mem_addr     = mem_addr_r;
  assign mem_wdata    = mem_wdata_r;
  assign count        = count_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign full         = full_r;
  assign err_illegal  = err_illegal_r;

  // Load FSM with registered handshake, write port, counter and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      in_ready_r     <= 1'b0;
      mem_we_r       <= 1'b0;
      mem_addr_r     <= BASE_ADDR;
      mem_wdata_r    <= 32'h0000_0000;
      count_r        <= '0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      full_r         <= 1'b0;
      err_illegal_r  <= 1'b0;
      last_r         <= 1'b0;
      restart_pend_r <= 1'b0;
    end else if (restart_s) begin
      state_r        <= ST_RUN;
      in_ready_r     <= 1'b1;
      mem_we_r       <= 1'b0;
      count_r        <= '0;
      busy_r         <= 1'b1;
      done_r         <= 1'b0;
      full_r         <= 1'b0;
      err_illegal_r  <= 1'b0;
      last_r         <= 1'b0;
      restart_pend_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (accept_s) begin
            if (illegal_s) begin
              err_illegal_r <= 1'b1;
            end else begin
              last_r      <= bus.in_last;
              mem_we_r    <= 1'b1;
              mem_addr_r  <= addr_s;
              mem_wdata_r <= word_s;
              in_ready_r  <= 1'b0;
              state_r     <= ST_WR;
            end
          end
        end
        ST_WR: begin
          mem_we_r <= 1'b0;
          count_r  <= count_r + {{IDXW{1'b0}}, 1'b1};
          if (start) begin
            restart_pend_r <= 1'b1;
          end
          if (last_r) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else if ((count_r + {{IDXW{1'b0}}, 1'b1}) == DEPTH_CNT) begin
            state_r <= ST_FULL;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            full_r  <= 1'b1;
          end else begin
            state_r    <= ST_RUN;
            in_ready_r <= 1'b1;
          end
        end
        ST_IDLE, ST_DONE, ST_FULL: begin
          in_ready_r <= 1'b0;
          mem_we_r   <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          in_ready_r <= 1'b0;
          mem_we_r   <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

endmodule
